check_ram: RTL and testbench
============================

CHECK_RAM -- requirements
Module: check_ram

Interface
REQ-001 Parameter DW, default 512, AXI data width in bits, power of two from 64 to 1024.
REQ-002 Parameter FILL_VALUE, default 8'hFC, expected value of every byte in the bank.
REQ-003 Parameter BASE_ADDR, default 64'h0, byte address of the first block in the bank.
REQ-004 Parameter BLOCK_BYTES, default 4096, byte stride between consecutive blocks.
REQ-005 Parameter BEATS_PER_BLOCK, default 64, burst length in beats, range 1..256.
REQ-006 Parameter BLOCKS, default 1024, number of blocks per bank, range 1..2^32-1.
REQ-007 Port clk, input, 1, the single clock; all logic is in this domain.
REQ-008 Port resetn, input, 1, asynchronous active-low reset.
REQ-009 Port start_async, input, 1, asynchronous start request; synchronized internally with a 2-flop synchronizer.
REQ-010 Port idle, output, 1, high when no check is in progress.
REQ-011 Port elapsed, output, 64, clock cycles taken by the most recent check.
REQ-012 Port error_count, output, 32, count of mismatching beats; saturates.
REQ-013 Port first_err_addr, output, 64, byte address of the first mismatching beat.
REQ-014 Port rresp_err, output, 1, sticky flag: some beat returned RRESP != 0.
REQ-015 Port rlast_err, output, 1, sticky flag: RLAST was misplaced.
REQ-016 Ports M_AXI_AR*: ARADDR[63:0], ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARID[3:0], ARLOCK, ARCACHE[3:0], ARQOS[3:0], ARPROT[2:0] and ARVALID are outputs; ARREADY is an input.
REQ-017 Ports M_AXI_RDATA[DW-1:0], RRESP[1:0], RLAST and RVALID are inputs; RREADY is an output.

Function
REQ-018 Constant AR fields: ARLEN = BEATS_PER_BLOCK-1, ARSIZE = log2(DW/8), ARBURST = 1 (INCR), all other AR fields 0.
REQ-019 M_AXI_RREADY is held at 1 at all times.
REQ-020 AR FSM, state IDLE, on a synchronized start pulse: ARADDR <= BASE_ADDR, ARVALID <= 1, block counter <= 1, go to ISSUE.
REQ-021 AR FSM, state ISSUE, on each ARVALID&ARREADY: if the block counter equals BLOCKS, ARVALID <= 0 and go to IDLE; otherwise ARADDR += BLOCK_BYTES and increment the block counter.
REQ-022 ARADDR and ARVALID stay stable while ARVALID=1 and ARREADY=0.
REQ-023 R FSM, state IDLE, on start: idle <= 0; elapsed, error_count, beat counter and block counter <= 0; rresp_err, rlast_err and the capture-valid flag <= 0; go to CHECK.
REQ-024 Each RVALID beat in CHECK is a mismatch if any byte of RDATA differs from FILL_VALUE.
REQ-025 Each mismatching beat increments error_count by 1, saturating at 32'hFFFFFFFF.
REQ-026 Beat address = BASE_ADDR + block_index*BLOCK_BYTES + beat_index*(DW/8).
REQ-027 RRESP != 0 on any beat sets rresp_err; the beat is still data-checked.
REQ-028 rlast_err is set if RLAST=1 on a beat other than beat BEATS_PER_BLOCK-1, or RLAST=0 on that beat.
REQ-029 The block counter advances on the beat whose index is BEATS_PER_BLOCK-1, whatever the value of RLAST.
REQ-030 When the last beat of block BLOCKS arrives, the R FSM goes to IDLE and idle <= 1 on the next edge.
REQ-031 elapsed increments every cycle while idle=0 and holds its value once idle=1.
REQ-032 A start received while idle=0 is ignored by both FSMs.
REQ-033 R beats arriving while idle=1 are accepted and discarded; no status output changes.
REQ-034 A beat on the same cycle as the start pulse is discarded.

Reset
REQ-035 While resetn=0, outputs are forced asynchronously: idle=1, ARVALID=0, elapsed=0, error_count=0, first_err_addr=0, rresp_err=0, rlast_err=0, ARADDR=0; both FSMs return to IDLE and the synchronizer is cleared.
REQ-036 Reset during a check abandons all outstanding bursts.
REQ-037 After resetn deasserts, the block waits for a new start.

Configuration
REQ-038 With macro CHECK_RAM_ERR_ADDR_CAPTURE_EN defined, first_err_addr captures the address of the first mismatching beat after each start and then holds it.
REQ-039 Without CHECK_RAM_ERR_ADDR_CAPTURE_EN, first_err_addr is constant 0 and the beat-address tracking logic is omitted.

Verification
REQ-040 BLOCKS=4, BEATS=4, all-0xFC memory, ARREADY=1 -> four AR bursts at BASE+0/4096/8192/12288; idle returns to 1; error_count=0; all flags 0.
REQ-041 Byte 5 of beat 2 of block 1 is 0x00 -> error_count=1; with the macro, first_err_addr=BASE+4096+2*64.
REQ-042 ARREADY low for 10 cycles and random RVALID gaps -> ARADDR stays stable while stalled; elapsed equals the cycle count from start to idle.
REQ-043 RLAST asserted on beat 1 of block 0 -> rlast_err=1; check still completes after 16 beats.
REQ-044 RRESP=2'b10 on one beat -> rresp_err=1; error_count unchanged if the data matches.
REQ-045 resetn pulsed low mid-check, then a new start -> outputs reset per REQ-035; the second check completes cleanly with error_count=0.

Source files
------------

// File: rtl/check_ram.sv
// check_ram: AXI4 read-back memory checker.
// After a start request, reads BLOCKS bursts of BEATS_PER_BLOCK beats and
// compares every byte against FILL_VALUE. It reports the mismatching beat
// count, the sticky RRESP and RLAST flags, and the cycles the check took.
// Optional feature: define CHECK_RAM_ERR_ADDR_CAPTURE_EN to record the byte
// address of the first mismatching beat in first_err_addr.
module check_ram #(
    parameter int unsigned DW              = 512,
    parameter logic [7:0]  FILL_VALUE      = 8'hFC,
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter int unsigned BLOCK_BYTES     = 4096,
    parameter int unsigned BEATS_PER_BLOCK = 64,
    parameter int unsigned BLOCKS          = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_async,
    output logic          idle,
    output logic [63:0]   elapsed,
    output logic [31:0]   error_count,
    output logic [63:0]   first_err_addr,
    output logic          rresp_err,
    output logic          rlast_err,
    output logic [63:0]   M_AXI_ARADDR,
    output logic [7:0]    M_AXI_ARLEN,
    output logic [2:0]    M_AXI_ARSIZE,
    output logic [1:0]    M_AXI_ARBURST,
    output logic [3:0]    M_AXI_ARID,
    output logic          M_AXI_ARLOCK,
    output logic [3:0]    M_AXI_ARCACHE,
    output logic [3:0]    M_AXI_ARQOS,
    output logic [2:0]    M_AXI_ARPROT,
    output logic          M_AXI_ARVALID,
    input  logic          M_AXI_ARREADY,
    input  logic [DW-1:0] M_AXI_RDATA,
    input  logic [1:0]    M_AXI_RRESP,
    input  logic          M_AXI_RLAST,
    input  logic          M_AXI_RVALID,
    output logic          M_AXI_RREADY
);

    localparam int unsigned   BEAT_BYTES = DW / 8;
    localparam logic [DW-1:0] FILL_WORD  = {BEAT_BYTES{FILL_VALUE}};
    localparam logic [7:0]    LAST_BEAT  = 8'(BEATS_PER_BLOCK - 1);
    localparam logic [31:0]   LAST_BLK   = 32'(BLOCKS - 1);
    localparam logic [31:0]   NUM_BLK    = 32'(BLOCKS);
    localparam logic [63:0]   BLK_STRIDE = 64'(BLOCK_BYTES);

    // Saturating increment for the mismatch counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF)
            return v;
        return v + 32'd1;
    endfunction

    // Constant burst shape and attributes.
    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_ARSIZE  = 3'($clog2(BEAT_BYTES));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARID    = 4'h0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'h0;
    assign M_AXI_ARQOS   = 4'h0;
    assign M_AXI_ARPROT  = 3'h0;
    assign M_AXI_RREADY  = 1'b1;

    //--------------------------------------------------------------------
    // Start synchronizer and rising-edge detect
    //--------------------------------------------------------------------
    logic start_sync_p0;
    logic start_sync_p1;
    logic start_sync_p2;
    logic start_pulse;
    logic start_ok;

    // Two flops resynchronize start_async; the third marks its previous level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            start_sync_p0 <= 1'b0;
            start_sync_p1 <= 1'b0;
            start_sync_p2 <= 1'b0;
        end else begin
            start_sync_p0 <= start_async;
            start_sync_p1 <= start_sync_p0;
            start_sync_p2 <= start_sync_p1;
        end
    end

    assign start_pulse = start_sync_p1 & ~start_sync_p2;
    // A start that arrives while a check is running is dropped by both FSMs.
    assign start_ok    = start_pulse & idle;

    //--------------------------------------------------------------------
    // AR channel FSM
    //--------------------------------------------------------------------
    typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;

    ar_state_t   ar_state;
    ar_state_t   ar_state_nxt;
    logic [63:0] araddr_nxt;
    logic        arvalid_nxt;
    logic [31:0] ar_blk;
    logic [31:0] ar_blk_nxt;

    // AR state, address, valid and issued-block count registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_state      <= AR_IDLE;
            M_AXI_ARADDR  <= 64'h0;
            M_AXI_ARVALID <= 1'b0;
            ar_blk        <= 32'h0;
        end else begin
            ar_state      <= ar_state_nxt;
            M_AXI_ARADDR  <= araddr_nxt;
            M_AXI_ARVALID <= arvalid_nxt;
            ar_blk        <= ar_blk_nxt;
        end
    end

    // Issue one burst per block; the address only moves on a handshake.
    always_comb begin
        ar_state_nxt = ar_state;
        araddr_nxt   = M_AXI_ARADDR;
        arvalid_nxt  = M_AXI_ARVALID;
        ar_blk_nxt   = ar_blk;
        case (ar_state)
            AR_IDLE: begin
                if (start_ok) begin
                    araddr_nxt   = BASE_ADDR;
                    arvalid_nxt  = 1'b1;
                    ar_blk_nxt   = 32'd1;
                    ar_state_nxt = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    if (ar_blk == NUM_BLK) begin
                        arvalid_nxt  = 1'b0;
                        ar_state_nxt = AR_IDLE;
                    end else begin
                        araddr_nxt = M_AXI_ARADDR + BLK_STRIDE;
                        ar_blk_nxt = ar_blk + 32'd1;
                    end
                end
            end
            default: ar_state_nxt = AR_IDLE;
        endcase
    end

    //--------------------------------------------------------------------
    // R channel FSM
    //--------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_CHECK} r_state_t;

    r_state_t    r_state;
    r_state_t    r_state_nxt;
    logic        idle_nxt;
    logic [63:0] elapsed_nxt;
    logic [31:0] error_count_nxt;
    logic        rresp_err_nxt;
    logic        rlast_err_nxt;
    logic [7:0]  beat_cnt;
    logic [7:0]  beat_cnt_nxt;
    logic [31:0] r_blk;
    logic [31:0] r_blk_nxt;

    logic        beat_fire;
    logic        beat_bad;
    logic        last_beat;

    // Beats outside a check (including one coinciding with start) are ignored.
    assign beat_fire = (r_state == R_CHECK) && M_AXI_RVALID;
    assign beat_bad  = (M_AXI_RDATA != FILL_WORD);
    assign last_beat = (beat_cnt == LAST_BEAT);

    // R state, status outputs and beat/block position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= R_IDLE;
            idle        <= 1'b1;
            elapsed     <= 64'h0;
            error_count <= 32'h0;
            rresp_err   <= 1'b0;
            rlast_err   <= 1'b0;
            beat_cnt    <= 8'h0;
            r_blk       <= 32'h0;
        end else begin
            r_state     <= r_state_nxt;
            idle        <= idle_nxt;
            elapsed     <= elapsed_nxt;
            error_count <= error_count_nxt;
            rresp_err   <= rresp_err_nxt;
            rlast_err   <= rlast_err_nxt;
            beat_cnt    <= beat_cnt_nxt;
            r_blk       <= r_blk_nxt;
        end
    end

    // Check each beat, track its position, and finish after the last block.
    always_comb begin
        r_state_nxt     = r_state;
        idle_nxt        = idle;
        elapsed_nxt     = elapsed;
        error_count_nxt = error_count;
        rresp_err_nxt   = rresp_err;
        rlast_err_nxt   = rlast_err;
        beat_cnt_nxt    = beat_cnt;
        r_blk_nxt       = r_blk;

        if (!idle)
            elapsed_nxt = elapsed + 64'd1;

        case (r_state)
            R_IDLE: begin
                if (start_ok) begin
                    idle_nxt        = 1'b0;
                    elapsed_nxt     = 64'h0;
                    error_count_nxt = 32'h0;
                    rresp_err_nxt   = 1'b0;
                    rlast_err_nxt   = 1'b0;
                    beat_cnt_nxt    = 8'h0;
                    r_blk_nxt       = 32'h0;
                    r_state_nxt     = R_CHECK;
                end
            end
            R_CHECK: begin
                if (beat_fire) begin
                    if (beat_bad)
                        error_count_nxt = sat_inc32(error_count);
                    if (M_AXI_RRESP != 2'b00)
                        rresp_err_nxt = 1'b1;
                    if (M_AXI_RLAST != last_beat)
                        rlast_err_nxt = 1'b1;
                    // Block position follows the beat count, not RLAST.
                    if (last_beat) begin
                        beat_cnt_nxt = 8'h0;
                        r_blk_nxt    = r_blk + 32'd1;
                        if (r_blk == LAST_BLK) begin
                            idle_nxt    = 1'b1;
                            r_state_nxt = R_IDLE;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt + 8'd1;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

`ifdef CHECK_RAM_ERR_ADDR_CAPTURE_EN
    //--------------------------------------------------------------------
    // First mismatch address capture
    //--------------------------------------------------------------------
    logic [63:0] beat_addr;
    logic [63:0] beat_addr_nxt;
    logic [63:0] blk_addr;
    logic [63:0] blk_addr_nxt;
    logic [63:0] first_err_nxt;
    logic        cap_vld;
    logic        cap_vld_nxt;

    // Walk the beat address alongside the R FSM; latch it on the first miss.
    always_comb begin
        beat_addr_nxt = beat_addr;
        blk_addr_nxt  = blk_addr;
        first_err_nxt = first_err_addr;
        cap_vld_nxt   = cap_vld;
        if (start_ok) begin
            beat_addr_nxt = BASE_ADDR;
            blk_addr_nxt  = BASE_ADDR;
            cap_vld_nxt   = 1'b0;
        end else if (beat_fire) begin
            if (beat_bad && !cap_vld) begin
                first_err_nxt = beat_addr;
                cap_vld_nxt   = 1'b1;
            end
            if (last_beat) begin
                blk_addr_nxt  = blk_addr + BLK_STRIDE;
                beat_addr_nxt = blk_addr + BLK_STRIDE;
            end else begin
                beat_addr_nxt = beat_addr + 64'(BEAT_BYTES);
            end
        end
    end

    // Address walkers are reloaded at every start, so they need no reset.
    always_ff @(posedge clk) begin
        beat_addr <= beat_addr_nxt;
        blk_addr  <= blk_addr_nxt;
    end

    // Captured address and its valid flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            first_err_addr <= 64'h0;
            cap_vld        <= 1'b0;
        end else begin
            first_err_addr <= first_err_nxt;
            cap_vld        <= cap_vld_nxt;
        end
    end
`else
    assign first_err_addr = 64'h0;
`endif

endmodule

// File: tb/tb_check_ram.sv
// tb_check_ram: directed and randomized bench for check_ram with a small
// AXI read responder that serves fill-pattern data with planned faults.
module tb_check_ram;

    localparam int          DW     = 512;
    localparam int          BEATS  = 4;
    localparam int          BLOCKS = 4;
    localparam int          BB     = 4096;
    localparam int          NBEAT  = BEATS * BLOCKS;
    localparam logic [63:0] BASE   = 64'h0000_0002_2000_0000;
    localparam logic [7:0]  FILL   = 8'hFC;
    localparam logic [DW-1:0] FILL_WORD = {(DW/8){FILL}};

    logic          clk;
    logic          resetn;
    logic          start_async;
    logic          idle;
    logic [63:0]   elapsed;
    logic [31:0]   error_count;
    logic [63:0]   first_err_addr;
    logic          rresp_err;
    logic          rlast_err;
    logic [63:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic [3:0]    ARID;
    logic          ARLOCK;
    logic [3:0]    ARCACHE;
    logic [3:0]    ARQOS;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;

    check_ram #(
        .DW(DW), .FILL_VALUE(FILL), .BASE_ADDR(BASE), .BLOCK_BYTES(BB),
        .BEATS_PER_BLOCK(BEATS), .BLOCKS(BLOCKS)
    ) dut (
        .clk(clk), .resetn(resetn), .start_async(start_async), .idle(idle),
        .elapsed(elapsed), .error_count(error_count), .first_err_addr(first_err_addr),
        .rresp_err(rresp_err), .rlast_err(rlast_err),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARID(ARID), .M_AXI_ARLOCK(ARLOCK),
        .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARQOS(ARQOS), .M_AXI_ARPROT(ARPROT),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
        .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory fault plan: byte lane to corrupt per beat (-1 none) and its value.
    int          cbyte [NBEAT];
    logic [7:0]  cval  [NBEAT];
    int          rlast_flip_idx = -1;
    int          rresp_idx      = -1;
    bit          ar_rand        = 0;
    bit          r_gap          = 0;
    int          ar_stall       = 0;
    bit          junk_mode      = 0;
    bit          idle_beat_req  = 0;

    // Responder / model bookkeeping.
    logic [63:0] ar_log [$];
    int          pend       = 0;
    int          rblk       = 0;
    int          rbeat      = 0;
    int          beats_sent = 0;
    int          busy_cyc   = 0;
    int          stall_viol = 0;
    bit          prev_stall = 0;
    logic [63:0] prev_addr  = 64'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // AXI slave model: serves one burst per accepted AR, all driven on negedge.
    initial begin : responder
        int idx;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = FILL_WORD;
        RRESP   = 2'b00;
        RLAST   = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend = 0; rblk = 0; rbeat = 0; prev_stall = 0;
                RVALID = 1'b0; ARREADY = 1'b0;
            end else begin
                if (prev_stall && !(ARVALID === 1'b1 && ARADDR === prev_addr))
                    stall_viol++;
                if (idle === 1'b0)
                    busy_cyc++;
                RVALID = 1'b0; RDATA = FILL_WORD; RRESP = 2'b00; RLAST = 1'b0;
                if (junk_mode) begin
                    if (idle) begin
                        RVALID = 1'b1; RDATA = '0; RRESP = 2'b10; RLAST = 1'b1;
                    end else begin
                        junk_mode = 0;
                    end
                end else if (idle_beat_req) begin
                    RVALID = 1'b1; RDATA = '0; RRESP = 2'b11; RLAST = 1'b0;
                    idle_beat_req = 0;
                end else if (pend > 0 && !(r_gap && $urandom_range(0, 2) == 0)) begin
                    idx    = rblk * BEATS + rbeat;
                    RVALID = 1'b1;
                    if (cbyte[idx] >= 0)
                        RDATA[8*cbyte[idx] +: 8] = cval[idx];
                    RLAST = ((rbeat == BEATS - 1) != (idx == rlast_flip_idx));
                    RRESP = (idx == rresp_idx) ? 2'b10 : 2'b00;
                    beats_sent++;
                    rbeat++;
                    if (rbeat == BEATS) begin
                        rbeat = 0; rblk++; pend--;
                    end
                end
                if (ar_stall > 0)
                    ARREADY = 1'b0;
                else
                    ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ar_stall > 0 && ARVALID)
                    ar_stall--;
                prev_stall = ARVALID && !ARREADY;
                prev_addr  = ARADDR;
                if (ARVALID && ARREADY) begin
                    ar_log.push_back(ARADDR);
                    pend++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic clear_plan();
        for (int i = 0; i < NBEAT; i++) begin
            cbyte[i] = -1;
            cval[i]  = FILL;
        end
        rlast_flip_idx = -1; rresp_idx = -1;
        ar_rand = 0; r_gap = 0; ar_stall = 0;
    endtask

    task automatic prep_run();
        ar_log.delete();
        rblk = 0; rbeat = 0; pend = 0; busy_cyc = 0; beats_sent = 0; stall_viol = 0;
    endtask

    // Start a check and wait (bounded) for it to finish.
    task automatic run_check(input string tag, input bit restart_mid);
        int n;
        prep_run();
        @(negedge clk);
        start_async = 1'b1;
        n = 0;
        while (idle && n < 20) begin @(negedge clk); n++; end
        chk({tag, " busy"}, 64'(idle), 64'h0);
        start_async = 1'b0;
        if (restart_mid) begin
            repeat (3) @(negedge clk);
            start_async = 1'b1;
            repeat (4) @(negedge clk);
            start_async = 1'b0;
        end
        n = 0;
        while (!idle && n < 3000) begin @(negedge clk); n++; end
        chk({tag, " done"}, 64'(idle), 64'h1);
    endtask

    task automatic check_ar(input string tag);
        chk({tag, " bursts"}, 64'(ar_log.size()), 64'(BLOCKS));
        for (int i = 0; i < BLOCKS && i < ar_log.size(); i++)
            chk($sformatf("%s araddr%0d", tag, i), ar_log[i], BASE + 64'(i) * 64'(BB));
    endtask

    task automatic check_status(input string tag, input int exp_err, input logic [63:0] exp_first,
                                input bit exp_rresp, input bit exp_rlast);
        chk({tag, " error_count"}, 64'(error_count), 64'(exp_err));
`ifdef CHECK_RAM_ERR_ADDR_CAPTURE_EN
        if (exp_err > 0)
            chk({tag, " first_err_addr"}, first_err_addr, exp_first);
`else
        chk({tag, " first_err_addr"}, first_err_addr, 64'h0);
`endif
        chk({tag, " rresp_err"}, 64'(rresp_err), 64'(exp_rresp));
        chk({tag, " rlast_err"}, 64'(rlast_err), 64'(exp_rlast));
        chk({tag, " elapsed"}, elapsed, 64'(busy_cyc));
        chk({tag, " stall_stable"}, 64'(stall_viol), 64'h0);
    endtask

    initial begin : stimulus
        int          n_err;
        int          first_idx;
        logic [63:0] exp_first;
        logic [7:0]  v;

        resetn      = 1'b0;
        start_async = 1'b0;
        clear_plan();
        repeat (3) @(negedge clk);

        // Reset values and constant AR fields.
        chk("rst idle", 64'(idle), 64'h1);
        chk("rst arvalid", 64'(ARVALID), 64'h0);
        chk("rst araddr", ARADDR, 64'h0);
        chk("rst elapsed", elapsed, 64'h0);
        chk("rst error_count", 64'(error_count), 64'h0);
        chk("rst first_err_addr", first_err_addr, 64'h0);
        chk("rst flags", {62'h0, rresp_err, rlast_err}, 64'h0);
        resetn = 1'b1;
        @(negedge clk);
        chk("arlen", 64'(ARLEN), 64'(BEATS - 1));
        chk("arsize", 64'(ARSIZE), 64'd6);
        chk("arburst", 64'(ARBURST), 64'd1);
        chk("ar misc", {46'h0, ARID, ARLOCK, ARCACHE, ARQOS, ARPROT}, 64'h0);
        chk("rready", 64'(RREADY), 64'h1);

        // Clean memory, ARREADY always high.
        clear_plan();
        run_check("clean", 0);
        check_ar("clean");
        check_status("clean", 0, 64'h0, 0, 0);

        // One bad byte: byte 5 of beat 2 of block 1.
        clear_plan();
        cbyte[1*BEATS + 2] = 5;
        cval[1*BEATS + 2]  = 8'h00;
        run_check("byte5", 0);
        check_status("byte5", 1, BASE + 64'(BB) + 64'd2 * 64'd64, 0, 0);

        // Stalled AR, random AR ready and R gaps, random corruption.
        clear_plan();
        ar_stall = 10; ar_rand = 1; r_gap = 1;
        n_err = 0; first_idx = -1;
        for (int i = 0; i < NBEAT; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cbyte[i] = $urandom_range(0, DW/8 - 1);
                v = 8'($urandom_range(0, 255));
                if (v == FILL) v = 8'h00;
                cval[i] = v;
                n_err++;
                if (first_idx < 0) first_idx = i;
            end
        end
        exp_first = (first_idx < 0) ? 64'h0 :
                    BASE + 64'(first_idx / BEATS) * 64'(BB) + 64'(first_idx % BEATS) * 64'd64;
        run_check("random", 0);
        check_ar("random");
        check_status("random", n_err, exp_first, 0, 0);

        // RLAST asserted early on beat 1 of block 0.
        clear_plan();
        rlast_flip_idx = 1;
        run_check("rlast", 0);
        chk("rlast beats", 64'(beats_sent), 64'(NBEAT));
        check_status("rlast", 0, 64'h0, 0, 1);

        // RRESP error on one random beat with good data.
        clear_plan();
        rresp_idx = $urandom_range(0, NBEAT - 1);
        run_check("rresp", 0);
        check_status("rresp", 0, 64'h0, 1, 0);

        // Junk beats up to and on the start cycle, plus a start during the check.
        clear_plan();
        junk_mode = 1;
        run_check("junk", 1);
        check_ar("junk");
        check_status("junk", 0, 64'h0, 0, 0);

        // A bad beat while idle changes nothing.
        idle_beat_req = 1;
        repeat (4) @(negedge clk);
        check_status("idlebeat", 0, 64'h0, 0, 0);

        // Reset in the middle of a check with corrupted data.
        clear_plan();
        for (int i = 0; i < NBEAT; i++) begin cbyte[i] = 0; cval[i] = 8'h11; end
        prep_run();
        @(negedge clk);
        start_async = 1'b1;
        repeat (12) @(negedge clk);
        start_async = 1'b0;
        chk("midrst busy", 64'(idle), 64'h0);
        #2 resetn = 1'b0;
        #1;
        chk("midrst idle", 64'(idle), 64'h1);
        chk("midrst arvalid", 64'(ARVALID), 64'h0);
        chk("midrst araddr", ARADDR, 64'h0);
        chk("midrst elapsed", elapsed, 64'h0);
        chk("midrst error_count", 64'(error_count), 64'h0);
        chk("midrst first_err_addr", first_err_addr, 64'h0);
        chk("midrst flags", {62'h0, rresp_err, rlast_err}, 64'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        chk("postrst waits", {62'h0, idle, ARVALID}, 64'h2);
        clear_plan();
        run_check("after_rst", 0);
        check_ar("after_rst");
        check_status("after_rst", 0, 64'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
